// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: channel FSM encoding and counter sizing.
package debounce_pkg;

    typedef enum logic {
        StStable  = 1'b0,
        StPending = 1'b1
    } deb_state_e;

    // Counter must hold the value DEBOUNCE_CYCLES itself.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input bit: metastability synchroniser followed by a two-state
// accept/reject FSM with a saturating hold counter.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter bit          REST_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o,
    output logic bounce_o
);

    localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level;
    deb_state_e             state_q;
    logic [CntW-1:0]        cnt_q;
    logic                   clean_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   bounce_q;

    // Plain shift chain; nothing may sit between these flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{REST_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign level = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StStable;
            cnt_q    <= '0;
            clean_q  <= REST_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                StStable: begin
                    if (level != clean_q) begin
                        state_q <= StPending;
                        cnt_q   <= CntW'(1);
                    end else begin
                        cnt_q <= '0;
                    end
                end
                StPending: begin
                    if (level == clean_q) begin
                        // Level fell back before confirmation: drop it and remember.
                        state_q  <= StStable;
                        cnt_q    <= '0;
                        bounce_q <= 1'b1;
                    end else if (cnt_q == CntMax) begin
                        state_q <= StStable;
                        cnt_q   <= '0;
                        clean_q <= level;
                        rise_q  <= level;
                        fall_q  <= ~level;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign clean_o  = clean_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign bounce_o = bounce_q;

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel synchroniser/debouncer for encoder contacts and push-buttons;
// each bit is handled by an independent debounce_channel.
module input_debouncer #(
    parameter int unsigned CHANNELS        = 3,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter bit          REST_STATE      = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] clean_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] bounce_seen
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REST_LEVEL     (REST_STATE)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (raw_in[i]),
            .clean_o (clean_out[i]),
            .rise_o  (rise_pulse[i]),
            .fall_o  (fall_pulse[i]),
            .bounce_o(bounce_seen[i])
        );
    end

endmodule
